serial_lsb_serializer: RTL
==========================

# serial_lsb_serializer

Parallel-to-serial front end for the serial two's-complement FSM. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock, LSB first, on a single-bit stream that drives the FSM's `in_bit` directly. It also emits a frame-start strobe so the downstream FSM can be cleared between words, and a last-bit marker for downstream framing.

## Interface
- `WIDTH`, 6: bits per word; legal range 2..32.
- `GAP`, 0: idle cycles inserted after each word's last bit; legal range 0..15.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  `in_data` is presented.
- `in_ready`  out  1  block accepts a word this cycle; a word transfers at a rising edge where `in_valid && in_ready`.
- `in_data`  in  WIDTH  word to serialize; bit 0 is sent first.
- `out_bit`  out  1  serial data; 0 when not shifting.
- `out_valid`  out  1  `out_bit` carries a data bit.
- `frame_start`  out  1  high during bit 0 of each word.
- `frame_last`  out  1  high during bit WIDTH-1 of each word.
- `busy`  out  1  state is not IDLE.

## Operation
- States are IDLE, SHIFT and GAP. The shift register is WIDTH bits. `bit_cnt` is $clog2(WIDTH) bits. `gap_cnt` is 4 bits.
- IDLE:
  - On an accept, load the shift register with `in_data`, set `bit_cnt`=0 and go to SHIFT.
- SHIFT:
  - `out_bit` = shreg[0] and `out_valid`=1.
  - Each edge shifts right (0 fills the MSB) and increments `bit_cnt`.
  - At the edge where `bit_cnt`=WIDTH-1: go to GAP with `gap_cnt`=GAP if GAP>0; otherwise take the frame-end load rule.
- GAP:
  - `out_valid`=0 and `out_bit`=0.
  - `gap_cnt` decrements each edge.
  - At the edge where `gap_cnt`=1, take the frame-end load rule.
- Frame-end load rule:
  - Without the buffer, go to IDLE.
  - With the buffer, see Configuration.
- `in_ready` is forced to 0 while `reset` is high.
- `frame_start`, `frame_last`, `out_valid` and `out_bit` are registered and decoded from state, `bit_cnt` and the shift register. They change only on clock edges.
- Reset, including mid-word:
  - state=IDLE and the counters clear.
  - The buffer becomes empty.
  - `out_bit`, `out_valid`, `frame_start`, `frame_last` and `busy` are 0 from the edge where reset is sampled.
  - The partial word is discarded and no `frame_last` is issued for it.
- `in_data` is sampled only at the accepting edge. Later changes to `in_data` have no effect.

## Timing
- If a word is accepted at edge N, bit k appears during the cycle after edge N+k, for k=0..WIDTH-1.
  - `frame_start` is high in the cycle after edge N.
  - `frame_last` is high in the cycle after edge N+WIDTH-1.
- The output latency from accept to bit 0 is 1 cycle.
- Word period without the buffer is WIDTH+GAP+1 cycles, because one IDLE cycle holds `in_ready` high.
- Word period with the buffer is WIDTH+GAP cycles when back-to-back words are available. `frame_last` of one word is immediately followed by `frame_start` of the next when GAP=0.
- The downstream FSM shifts every clock. `frame_start` is the per-word clear for the FSM.

## Configuration
- `SERIALIZER_SKID_BUF_EN` defined:
  - Adds a one-entry holding buffer, and `in_ready` = !buf_full in every state.
  - A word accepted while in IDLE with the buffer empty bypasses the buffer and loads the shifter directly.
  - A word accepted in SHIFT or GAP fills the buffer.
  - At a frame end with the buffer full, the buffered word loads into SHIFT on that same edge and the buffer empties.
  - At a frame end with the buffer empty and `in_valid`=1, the incoming word loads directly into SHIFT.
  - Otherwise the state goes to IDLE.
- Macro undefined:
  - No buffer, and `in_ready` = (state==IDLE) && !reset.
  - The frame-end load rule always goes to IDLE.

## Test plan
- **Reset values:** hold reset 3 cycles, then release. All outputs are 0 during reset. `in_ready`=1 in the first cycle after release.
- **Single word, WIDTH=6, GAP=0:** `in_data`=6'b100111. `out_bit` is 1,1,1,0,0,1 on the 6 cycles after accept. `frame_start` is on bit 0 and `frame_last` on bit 5. With the two's-complement FSM cleared on `frame_start`, its output reads 6'b011001.
- **Gap, GAP=2:** send two words back-to-back. `out_valid` is low for exactly 2 cycles between `frame_last` and the next `frame_start`. The buffer adds nothing extra; without the buffer there is one additional IDLE cycle.
- **Skid buffer, macro defined, GAP=0:** hold `in_valid` high with words 6'h15, then 6'h2A, then 6'h3F.
  - The stream is 18 contiguous valid bits, LSB-first per word.
  - `in_ready` drops when the buffer is full.
  - No word is lost or duplicated.
- **Reset mid-word:** assert reset at bit 3.
  - `out_valid`=0 from the next edge, and no `frame_last` is issued for the partial word.
  - The next accepted word starts cleanly with `frame_start`.
- **Data stability:** change `in_data` every cycle after an accept. The serialized bits match the value sampled at the accepting edge.

Source files
------------

// File: rtl/serial_lsb_serializer.sv
// serial_lsb_serializer
//
// Parallel-to-serial front end for the serial two's-complement FSM. Words of
// WIDTH bits come in over a valid/ready handshake and leave one bit per clock,
// LSB first. A frame_start strobe marks bit 0 of every word so the downstream
// FSM can be cleared, and frame_last marks bit WIDTH-1. GAP idle cycles follow
// each word's last bit.
//
// Optional feature: define SERIALIZER_SKID_BUF_EN to add a one-entry holding
// buffer. Back-to-back words then stream with no IDLE cycle between frames.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous, active-high
//   in_valid     in_data is presented
//   in_ready     a word transfers at an edge where in_valid && in_ready
//   in_data      word to serialize, bit 0 goes out first
//   out_bit      serial data, 0 when not shifting
//   out_valid    out_bit carries a data bit
//   frame_start  high during bit 0 of each word
//   frame_last   high during bit WIDTH-1 of each word
//   busy         state is not IDLE

module serial_lsb_serializer #(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned GAP   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_bit,
   output logic             out_valid,
   output logic             frame_start,
   output logic             frame_last,
   output logic             busy
);

   localparam int unsigned   CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
   localparam logic [3:0]    GapInit = 4'(GAP);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StGap
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  shreg_q, shreg_d;
   logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [3:0]        gap_cnt_q, gap_cnt_d;

   logic              out_bit_q, out_bit_d;
   logic              out_valid_q, out_valid_d;
   logic              frame_start_q, frame_start_d;
   logic              frame_last_q, frame_last_d;

   logic              accept;
   logic              frame_end;
   logic              load_en;
   logic [WIDTH-1:0]  load_data;

`ifdef SERIALIZER_SKID_BUF_EN
   logic              buf_full_q, buf_full_d;
   logic [WIDTH-1:0]  buf_data_q, buf_data_d;

   assign in_ready = !buf_full_q && !reset;
`else
   assign in_ready = (state_q == StIdle) && !reset;
`endif

   assign accept = in_valid && in_ready;
   assign busy   = (state_q != StIdle);

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      frame_end = 1'b0;
      load_en   = 1'b0;
      load_data = in_data;
`ifdef SERIALIZER_SKID_BUF_EN
      buf_full_d = buf_full_q;
      buf_data_d = buf_data_q;
`endif

      case (state_q)
         StIdle: begin
            // The buffer is always empty in IDLE, so an accept loads the shifter.
            if (accept) begin
               load_en = 1'b1;
            end
         end
         StShift: begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + CntW'(1);
            if (bit_cnt_q == LastCnt) begin
               if (GAP > 0) begin
                  state_d   = StGap;
                  gap_cnt_d = GapInit;
               end else begin
                  frame_end = 1'b1;
               end
            end
         end
         StGap: begin
            gap_cnt_d = gap_cnt_q - 4'd1;
            if (gap_cnt_q == 4'd1) begin
               frame_end = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (frame_end) begin
`ifdef SERIALIZER_SKID_BUF_EN
         if (buf_full_q) begin
            load_en    = 1'b1;
            load_data  = buf_data_q;
            buf_full_d = 1'b0;
         end else if (accept) begin
            // Buffer empty, so in_ready is high: the new word goes straight in.
            load_en = 1'b1;
         end else begin
            state_d = StIdle;
         end
`else
         state_d = StIdle;
`endif
      end

`ifdef SERIALIZER_SKID_BUF_EN
      // Words arriving mid-frame wait in the buffer until the frame ends.
      if (accept && (state_q != StIdle) && !frame_end) begin
         buf_full_d = 1'b1;
         buf_data_d = in_data;
      end
`endif

      if (load_en) begin
         state_d   = StShift;
         shreg_d   = load_data;
         bit_cnt_d = '0;
      end

      // Outputs are registered copies of what the next state decodes to, so
      // they describe the bit on the wire during the following cycle.
      out_valid_d   = (state_d == StShift);
      out_bit_d     = out_valid_d && shreg_d[0];
      frame_start_d = out_valid_d && (bit_cnt_d == '0);
      frame_last_d  = out_valid_d && (bit_cnt_d == LastCnt);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         shreg_q       <= '0;
         bit_cnt_q     <= '0;
         gap_cnt_q     <= '0;
         out_bit_q     <= 1'b0;
         out_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         frame_last_q  <= 1'b0;
`ifdef SERIALIZER_SKID_BUF_EN
         buf_full_q    <= 1'b0;
         buf_data_q    <= '0;
`endif
      end else begin
         state_q       <= state_d;
         shreg_q       <= shreg_d;
         bit_cnt_q     <= bit_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         out_bit_q     <= out_bit_d;
         out_valid_q   <= out_valid_d;
         frame_start_q <= frame_start_d;
         frame_last_q  <= frame_last_d;
`ifdef SERIALIZER_SKID_BUF_EN
         buf_full_q    <= buf_full_d;
         buf_data_q    <= buf_data_d;
`endif
      end
   end

   assign out_bit     = out_bit_q;
   assign out_valid   = out_valid_q;
   assign frame_start = frame_start_q;
   assign frame_last  = frame_last_q;

endmodule
